// File: rtl/al_accel_pkg.sv
// Shared constants and types for the alpha-accelerator control-window sequencer.
package al_accel_pkg;

  // Register window of the accelerator control slave
  localparam logic [31:0] REG_BASE_ADDR = 32'h0200_1000;
  localparam logic [31:0] CTRL_REG_ADDR = 32'h0200_1050;

  // Control codes written to CTRL
  localparam logic [31:0] CTRL_RST = 32'd0;
  localparam logic [31:0] CTRL_CFG = 32'd1;
  localparam logic [31:0] CTRL_RUN = 32'd2;

  // Slave status code read back from CTRL[1:0]
  localparam logic [1:0]  ST_FIN   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ENTER_CFG = 3'd1,
    S_WR_CFG    = 3'd2,
    S_START_RUN = 3'd3,
    S_POLL      = 3'd4,
    S_CLEAR     = 3'd5,
    S_DONE      = 3'd6
  } seq_state_e;

  // Word address of config register idx relative to the window base
  function automatic logic [31:0] cfg_reg_addr(input logic [31:0] base,
                                               input logic [4:0]  idx);
    return base + {25'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/al_accel_cfg_seq.sv
// Hardware initiator for the alpha-accelerator control window: enters CFG,
// streams the config words, starts RUN, polls for FIN (bounded), then
// returns the slave to CTRL=0 and reports completion.
//
// Bus semantics: al_accel_mem_valid is a write strobe with no back-pressure.
// Every cycle it is high, exactly one write of al_accel_ctrl_wdata to
// al_accel_ctrl_waddr takes place; the slave always accepts. Reads are
// combinational: al_accel_ctrl_raddr is presented and al_accel_ctrl_rdata is
// sampled in the same cycle. Address/data outputs are 0 whenever unused.
module al_accel_cfg_seq
  import al_accel_pkg::*;
#(
  parameter int          NUM_CFG_REGS = 17,
  parameter logic [31:0] BASE_ADDR    = REG_BASE_ADDR,
  parameter logic [31:0] CTRL_ADDR    = CTRL_REG_ADDR,
  parameter int          POLL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  cfg_idx,
  input  logic [31:0] cfg_data,
  output logic        busy,
  output logic        done,
  output logic        timeout_err,
  output logic        al_accel_mem_valid,
  output logic [31:0] al_accel_ctrl_waddr,
  output logic [31:0] al_accel_ctrl_wdata,
  output logic [31:0] al_accel_ctrl_raddr,
  input  logic [31:0] al_accel_ctrl_rdata,
  output seq_state_e  dbg_state_o
);

  localparam int             CNT_W    = $clog2(POLL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_TIMEOUT - 1);
  localparam logic [4:0]     IDX_LAST = 5'(NUM_CFG_REGS - 1);

  seq_state_e       state_q;
  logic [4:0]       cfg_idx_q;
  logic [CNT_W-1:0] poll_cnt_q;
  logic             timeout_err_q;
  logic             aborted_q;

  // Only the status field of the read word carries meaning here
  logic [29:0] unused_rdata;
  assign unused_rdata = al_accel_ctrl_rdata[31:2];

  // Sequencer: state, config index, poll counter and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cfg_idx_q     <= '0;
      poll_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            timeout_err_q <= 1'b0;
            aborted_q     <= 1'b0;
            state_q       <= S_ENTER_CFG;
          end
        end
        S_ENTER_CFG: begin
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= S_CLEAR;
          end else if (NUM_CFG_REGS == 0) begin
            state_q <= S_START_RUN;
          end else begin
            state_q <= S_WR_CFG;
          end
        end
        S_WR_CFG: begin
          if (abort) begin
            aborted_q <= 1'b1;
            cfg_idx_q <= '0;
            state_q   <= S_CLEAR;
          end else if (cfg_idx_q == IDX_LAST) begin
            cfg_idx_q <= '0;
            state_q   <= S_START_RUN;
          end else begin
            cfg_idx_q <= cfg_idx_q + 5'd1;
          end
        end
        S_START_RUN: begin
          poll_cnt_q <= '0;
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= S_CLEAR;
          end else begin
            state_q <= S_POLL;
          end
        end
        S_POLL: begin
          // abort wins over FIN and over a timeout landing in the same cycle
          if (abort) begin
            aborted_q <= 1'b1;
            state_q   <= S_CLEAR;
          end else if (al_accel_ctrl_rdata[1:0] == ST_FIN) begin
            state_q <= S_CLEAR;
          end else if (poll_cnt_q == CNT_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_CLEAR;
          end else begin
            poll_cnt_q <= poll_cnt_q + CNT_W'(1);
          end
        end
        S_CLEAR: begin
          state_q <= aborted_q ? S_IDLE : S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Bus decode from registered state; config data passes straight through
  always_comb begin
    al_accel_mem_valid  = 1'b0;
    al_accel_ctrl_waddr = 32'd0;
    al_accel_ctrl_wdata = 32'd0;
    al_accel_ctrl_raddr = 32'd0;
    case (state_q)
      S_ENTER_CFG: begin
        al_accel_mem_valid  = 1'b1;
        al_accel_ctrl_waddr = CTRL_ADDR;
        al_accel_ctrl_wdata = CTRL_CFG;
      end
      S_WR_CFG: begin
        al_accel_mem_valid  = 1'b1;
        al_accel_ctrl_waddr = cfg_reg_addr(BASE_ADDR, cfg_idx_q);
        al_accel_ctrl_wdata = cfg_data;
      end
      S_START_RUN: begin
        al_accel_mem_valid  = 1'b1;
        al_accel_ctrl_waddr = CTRL_ADDR;
        al_accel_ctrl_wdata = CTRL_RUN;
      end
      S_POLL: begin
        al_accel_ctrl_raddr = CTRL_ADDR;
      end
      S_CLEAR: begin
        al_accel_mem_valid  = 1'b1;
        al_accel_ctrl_waddr = CTRL_ADDR;
        al_accel_ctrl_wdata = CTRL_RST;
      end
      default: begin
      end
    endcase
  end

  assign cfg_idx     = cfg_idx_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign timeout_err = timeout_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_al_accel_cfg_seq.sv
// Bench for al_accel_cfg_seq: two instances (17 config words / timeout 8 and
// 0 config words / timeout 4) share start/abort/reset. A queue-of-bus-actions
// model predicts every output each cycle; directed scenarios add literal
// expectations for write order, cycle positions and the abort/reset cases.
module tb_al_accel_cfg_seq;
  import al_accel_pkg::*;

  localparam int          NREG_A = 17;
  localparam int          NREG_B = 0;
  localparam int          TMO_A  = 8;
  localparam int          TMO_B  = 4;
  localparam logic [31:0] CTRL   = 32'h0200_1050;
  localparam logic [31:0] BASE   = 32'h0200_1000;
  localparam logic [1:0]  K_WR   = 2'd0;
  localparam logic [1:0]  K_POLL = 2'd1;
  localparam logic [1:0]  K_CLR  = 2'd2;
  localparam logic [1:0]  K_DONE = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic abort;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic [4:0]  cfg_idx_w [2];
  logic [31:0] cfg_data_w[2];
  logic        busy_w    [2];
  logic        done_w    [2];
  logic        terr_w    [2];
  logic        mv_w      [2];
  logic [31:0] waddr_w   [2];
  logic [31:0] wdata_w   [2];
  logic [31:0] raddr_w   [2];
  logic [31:0] rdata_w   [2];
  seq_state_e  dbg_w     [2];
  logic [1:0]  st        [2];

  for (genvar g = 0; g < 2; g++) begin : g_src
    assign cfg_data_w[g] = 32'hA000_0000 + {27'd0, cfg_idx_w[g]};
    assign rdata_w[g]    = (raddr_w[g] == CTRL) ? {30'd0, st[g]} : 32'd0;
  end

  al_accel_cfg_seq #(.NUM_CFG_REGS(NREG_A), .BASE_ADDR(BASE), .CTRL_ADDR(CTRL),
                     .POLL_TIMEOUT(TMO_A)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_idx(cfg_idx_w[0]), .cfg_data(cfg_data_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .timeout_err(terr_w[0]), .al_accel_mem_valid(mv_w[0]),
    .al_accel_ctrl_waddr(waddr_w[0]), .al_accel_ctrl_wdata(wdata_w[0]),
    .al_accel_ctrl_raddr(raddr_w[0]), .al_accel_ctrl_rdata(rdata_w[0]),
    .dbg_state_o(dbg_w[0]));

  al_accel_cfg_seq #(.NUM_CFG_REGS(NREG_B), .BASE_ADDR(BASE), .CTRL_ADDR(CTRL),
                     .POLL_TIMEOUT(TMO_B)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_idx(cfg_idx_w[1]), .cfg_data(cfg_data_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .timeout_err(terr_w[1]), .al_accel_mem_valid(mv_w[1]),
    .al_accel_ctrl_waddr(waddr_w[1]), .al_accel_ctrl_wdata(wdata_w[1]),
    .al_accel_ctrl_raddr(raddr_w[1]), .al_accel_ctrl_rdata(rdata_w[1]),
    .dbg_state_o(dbg_w[1]));

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted start enqueues the full list of bus actions; one action is
  // consumed per cycle, POLL stays at the head until FIN or the budget runs out.
  typedef struct packed {
    logic [1:0]  kind;
    logic [4:0]  idx;
    logic [31:0] addr;
    logic [31:0] data;
  } item_t;

  item_t mq [2][64];
  int    hd     [2] = '{0, 0};
  int    cnt    [2] = '{0, 0};
  int    polls_m[2] = '{0, 0};
  logic  terr_m [2] = '{1'b0, 1'b0};

  function automatic item_t mk(input logic [1:0] k, input logic [4:0] ix,
                               input logic [31:0] a, input logic [31:0] d);
    item_t it;
    it.kind = k; it.idx = ix; it.addr = a; it.data = d;
    return it;
  endfunction

  function automatic int nreg(input int m);
    return (m == 0) ? NREG_A : NREG_B;
  endfunction

  function automatic int tmo(input int m);
    return (m == 0) ? TMO_A : TMO_B;
  endfunction

  task automatic m_push(input int m, input item_t it);
    mq[m][(hd[m] + cnt[m]) % 64] = it;
    cnt[m]++;
  endtask

  task automatic m_pop(input int m);
    hd[m] = (hd[m] + 1) % 64;
    cnt[m]--;
  endtask

  task automatic m_step(input int m);
    item_t f;
    if (cnt[m] == 0) begin
      if (start && !abort) begin
        terr_m[m]  = 1'b0;
        polls_m[m] = 0;
        m_push(m, mk(K_WR, 5'd0, CTRL, 32'd1));
        for (int i = 0; i < nreg(m); i++)
          m_push(m, mk(K_WR, 5'(i), BASE + 32'(4 * i), 32'hA000_0000 + 32'(i)));
        m_push(m, mk(K_WR, 5'd0, CTRL, 32'd2));
        m_push(m, mk(K_POLL, 5'd0, 32'd0, 32'd0));
      end
    end else begin
      f = mq[m][hd[m]];
      if (abort && (f.kind == K_WR || f.kind == K_POLL)) begin
        hd[m]  = 0;
        cnt[m] = 0;
        m_push(m, mk(K_CLR, 5'd0, CTRL, 32'd0));
      end else if (f.kind == K_POLL) begin
        polls_m[m]++;
        if (st[m] == 2'd3 || polls_m[m] == tmo(m)) begin
          if (st[m] != 2'd3) terr_m[m] = 1'b1;
          m_pop(m);
          m_push(m, mk(K_CLR, 5'd0, CTRL, 32'd0));
          m_push(m, mk(K_DONE, 5'd0, 32'd0, 32'd0));
        end
      end else begin
        m_pop(m);
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        hd[m] = 0; cnt[m] = 0; polls_m[m] = 0; terr_m[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) m_step(m);
    end
  end

  function automatic logic [104:0] exp_out(input int m);
    item_t f;
    logic b, d, v;
    logic [31:0] wa, wd, ra;
    logic [4:0] ix;
    b = 1'b0; d = 1'b0; v = 1'b0; wa = 32'd0; wd = 32'd0; ra = 32'd0; ix = 5'd0;
    if (cnt[m] != 0) begin
      f = mq[m][hd[m]];
      b = 1'b1;
      case (f.kind)
        K_WR, K_CLR: begin v = 1'b1; wa = f.addr; wd = f.data; ix = f.idx; end
        K_POLL:      ra = CTRL;
        default:     d = 1'b1;
      endcase
    end
    return {b, d, terr_m[m], v, wa, wd, ra, ix};
  endfunction

  function automatic logic [104:0] got_out(input int m);
    return {busy_w[m], done_w[m], terr_w[m], mv_w[m], waddr_w[m], wdata_w[m],
            raddr_w[m], cfg_idx_w[m]};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("outputs_dut%0d", m), 128'(got_out(m)), 128'(exp_out(m)));
      chk($sformatf("dbg_idle_dut%0d", m), 128'(dbg_w[m] == S_IDLE), 128'(cnt[m] == 0));
    end
  end

  // ---------------- slave status source and write log ----------------
  int          fin_mode[2] = '{1, 1};  // 0 never FIN, 1 FIN after fin_at polls, 2 random
  int          fin_at  [2] = '{0, 0};
  int          seen    [2] = '{0, 0};
  int          poll_cyc[2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  int          done_stamp_a = 0;
  logic [63:0] log_a[$];
  logic [63:0] log_b[$];
  int          log_a_cyc[$];
  int          log_b_cyc[$];
  logic [63:0] exp_q[$];
  int          start_cyc = 0;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (done_w[m]) done_cnt[m]++;
      if (raddr_w[m] == CTRL) begin
        poll_cyc[m]++;
        seen[m]++;
        case (fin_mode[m])
          0:       st[m] = 2'd2;
          1:       st[m] = (seen[m] > fin_at[m]) ? 2'd3 : 2'd2;
          default: st[m] = ($urandom_range(0, 3) == 0) ? 2'd3 : 2'd2;
        endcase
      end else begin
        seen[m] = 0;
        st[m]   = 2'd0;
      end
    end
    if (done_w[0]) done_stamp_a = cyc;
    if (mv_w[0]) begin log_a.push_back({waddr_w[0], wdata_w[0]}); log_a_cyc.push_back(cyc); end
    if (mv_w[1]) begin log_b.push_back({waddr_w[1], wdata_w[1]}); log_b_cyc.push_back(cyc); end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    log_a.delete(); log_b.delete(); log_a_cyc.delete(); log_b_cyc.delete();
    for (int m = 0; m < 2; m++) begin poll_cyc[m] = 0; done_cnt[m] = 0; end
  endtask

  task automatic pulse_start();
    start_cyc = cyc + 1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int m);
    int b;
    b = 0;
    while (busy_w[m] && b < 300) begin tick(1); b++; end
    chk($sformatf("idle_reached_dut%0d", m), 128'(busy_w[m]), 128'd0);
  endtask

  task automatic check_log_a(input string tag);
    chk({tag, "_log_len"}, 128'(log_a.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < log_a.size()) chk($sformatf("%s_write%0d", tag, i), 128'(log_a[i]), 128'(exp_q[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b;
    int n;
    int hits;
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;

    // Literal write list for a full 17-word run
    exp_q.push_back({32'h0200_1050, 32'd1});
    for (int i = 0; i < 17; i++)
      exp_q.push_back({32'h0200_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
    exp_q.push_back({32'h0200_1050, 32'd2});
    exp_q.push_back({32'h0200_1050, 32'd0});

    tick(3);
    chk("reset_out_a", 128'(got_out(0)), 128'd0);
    chk("reset_out_b", 128'(got_out(1)), 128'd0);
    reset = 1'b0;
    tick(2);

    // Normal run: A sees FIN on its sixth poll cycle, B on its first
    fin_mode[0] = 1; fin_mode[1] = 1; fin_at[0] = 5; fin_at[1] = 0;
    clear_logs();
    pulse_start();
    wait_idle(0);
    wait_idle(1);
    check_log_a("normal");
    chk("normal_polls_a", 128'(poll_cyc[0]), 128'd6);
    chk("normal_done_a", 128'(done_cnt[0]), 128'd1);
    chk("normal_terr_a", 128'(terr_w[0]), 128'd0);
    chk("normal_done_cycle_a", 128'(done_stamp_a - start_cyc), 128'd26);
    if (log_a_cyc.size() > 18) chk("normal_run_cycle_a", 128'(log_a_cyc[18] - start_cyc), 128'd18);
    chk("n0_log_len", 128'(log_b.size()), 128'd3);
    if (log_b.size() >= 3) begin
      chk("n0_write0", 128'(log_b[0]), 128'({32'h0200_1050, 32'd1}));
      chk("n0_write1", 128'(log_b[1]), 128'({32'h0200_1050, 32'd2}));
      chk("n0_write2", 128'(log_b[2]), 128'({32'h0200_1050, 32'd0}));
      chk("n0_cycle0", 128'(log_b_cyc[0] - start_cyc), 128'd0);
      chk("n0_cycle1", 128'(log_b_cyc[1] - start_cyc), 128'd1);
    end
    chk("n0_polls_b", 128'(poll_cyc[1]), 128'd1);

    // Timeout: slave never reports FIN
    fin_mode[0] = 0; fin_mode[1] = 0;
    clear_logs();
    pulse_start();
    wait_idle(0);
    wait_idle(1);
    chk("tmo_polls_a", 128'(poll_cyc[0]), 128'd8);
    chk("tmo_polls_b", 128'(poll_cyc[1]), 128'd4);
    chk("tmo_terr_a", 128'(terr_w[0]), 128'd1);
    chk("tmo_terr_b", 128'(terr_w[1]), 128'd1);
    chk("tmo_done_a", 128'(done_cnt[0]), 128'd1);
    if (log_a.size() > 0) chk("tmo_last_write_a", 128'(log_a[log_a.size() - 1]), 128'({32'h0200_1050, 32'd0}));
    fin_mode[0] = 1; fin_mode[1] = 1; fin_at[0] = 0; fin_at[1] = 0;
    pulse_start();
    chk("tmo_terr_cleared_a", 128'(terr_w[0]), 128'd0);
    wait_idle(0);
    wait_idle(1);

    // Abort while REG_4 is being written: REG_5 never appears
    fin_mode[1] = 0;
    clear_logs();
    pulse_start();
    b = 0;
    while (cfg_idx_w[0] != 5'd4 && b < 40) begin tick(1); b++; end
    chk("abort_reached_idx4", 128'(cfg_idx_w[0]), 128'd4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_idle(0);
    wait_idle(1);
    hits = 0;
    foreach (log_a[i]) if (log_a[i][63:32] == 32'h0200_1014) hits++;
    chk("abort_no_reg5", 128'(hits), 128'd0);
    chk("abort_log_len", 128'(log_a.size()), 128'd7);
    if (log_a.size() >= 2) begin
      chk("abort_last_write", 128'(log_a[log_a.size() - 1]), 128'({32'h0200_1050, 32'd0}));
      chk("abort_prev_write", 128'(log_a[log_a.size() - 2]), 128'({32'h0200_1010, 32'hA000_0004}));
    end
    chk("abort_no_done", 128'(done_cnt[0]), 128'd0);

    // start pulsed during POLL is ignored
    fin_mode[0] = 1; fin_mode[1] = 1; fin_at[0] = 6; fin_at[1] = 2;
    clear_logs();
    pulse_start();
    b = 0;
    while (raddr_w[0] != CTRL && b < 40) begin tick(1); b++; end
    chk("poll_reached_a", 128'(raddr_w[0]), 128'(CTRL));
    tick(2);
    pulse_start();
    wait_idle(0);
    wait_idle(1);
    check_log_a("restart");
    chk("restart_polls_a", 128'(poll_cyc[0]), 128'd7);
    chk("restart_done_a", 128'(done_cnt[0]), 128'd1);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_a", 128'(busy_w[0]), 128'd0);
    chk("start_abort_idle_b", 128'(busy_w[1]), 128'd0);

    // reset during START_RUN drops everything at once, no CLEAR write
    clear_logs();
    pulse_start();
    b = 0;
    while (!(mv_w[0] && waddr_w[0] == CTRL && wdata_w[0] == 32'd2) && b < 40) begin tick(1); b++; end
    chk("run_write_reached_a", 128'(wdata_w[0]), 128'd2);
    reset = 1'b1;
    #1;
    chk("midreset_out_a", 128'(got_out(0)), 128'd0);
    chk("midreset_out_b", 128'(got_out(1)), 128'd0);
    n = log_a.size();
    tick(3);
    reset = 1'b0;
    tick(4);
    chk("midreset_no_writes_a", 128'(log_a.size()), 128'(n));
    chk("midreset_busy_a", 128'(busy_w[0]), 128'd0);
    chk("midreset_no_done_a", 128'(done_cnt[0]), 128'd0);

    // Randomized traffic checked by the model every cycle
    for (int it = 0; it < 25; it++) begin
      fin_mode[0] = 2;
      fin_mode[1] = $urandom_range(0, 2);
      fin_at[1]   = $urandom_range(0, 5);
      for (int c = 0; c < 80; c++) begin
        start = ($urandom_range(0, 5) == 0);
        abort = ($urandom_range(0, 24) == 0);
        if ($urandom_range(0, 299) == 0) reset = 1'b1;
        tick(1);
        reset = 1'b0;
      end
    end
    start = 1'b0;
    abort = 1'b0;
    wait_idle(0);
    wait_idle(1);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
